// File: rtl/timer_countdown_if.sv
// Control and display bundle for timer_countdown: preset/command inputs, digit and status outputs.
// The scan_data/scan_sel pair only exists when TIMER_DISPLAY_MUX_EN is defined.
interface timer_countdown_if;
    logic        load;
    logic [7:0]  preset_min;
    logic [7:0]  preset_sec;
    logic        start;
    logic        pause;
    logic        fault;
    logic        clear;
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        error;
`ifdef TIMER_DISPLAY_MUX_EN
    logic [3:0]  scan_data;
    logic [3:0]  scan_sel;

    modport master (
        output load, preset_min, preset_sec, start, pause, fault, clear,
        input  digits, running, done, error, scan_data, scan_sel
    );
    modport slave (
        input  load, preset_min, preset_sec, start, pause, fault, clear,
        output digits, running, done, error, scan_data, scan_sel
    );
`else
    modport master (
        output load, preset_min, preset_sec, start, pause, fault, clear,
        input  digits, running, done, error
    );
    modport slave (
        input  load, preset_min, preset_sec, start, pause, fault, clear,
        output digits, running, done, error
    );
`endif
endinterface

// File: rtl/timer_countdown.sv
// BCD mm:ss countdown timer with run/done/error status and an "Erro" glyph in ERROR.
// Optional multiplexed display scan outputs are enabled by defining TIMER_DISPLAY_MUX_EN.
module timer_countdown #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_countdown_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] ERRO_CODE = 16'hCEEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    generate
        if (TICK_DIV < 2) begin : g_bad_tick
            $error("timer_countdown: TICK_DIV must be at least 2");
        end
        if (SCAN_DIV < 1) begin : g_bad_scan
            $error("timer_countdown: SCAN_DIV must be at least 1");
        end
    endgenerate

    // A preset is legal when every digit is decimal and the seconds tens digit is at most 5.
    function automatic logic preset_valid(input logic [7:0] mins, input logic [7:0] secs);
        preset_valid = (mins[7:4] <= 4'd9) && (mins[3:0] <= 4'd9) &&
                       (secs[7:4] <= 4'd5) && (secs[3:0] <= 4'd9);
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
        logic       borrow;
        {mt, mu, st, su} = t;
        if (su == 4'd0) begin
            su     = 4'd9;
            borrow = 1'b1;
        end else begin
            su     = su - 4'd1;
            borrow = 1'b0;
        end
        if (borrow) begin
            if (st == 4'd0) begin
                st = 4'd5;
            end else begin
                st     = st - 4'd1;
                borrow = 1'b0;
            end
        end else begin
            st = st;
        end
        if (borrow) begin
            if (mu == 4'd0) begin
                mu = 4'd9;
            end else begin
                mu     = mu - 4'd1;
                borrow = 1'b0;
            end
        end else begin
            mu = mu;
        end
        if (borrow) begin
            mt = mt - 4'd1;
        end else begin
            mt = mt;
        end
        bcd_dec = {mt, mu, st, su};
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] count_r;
    logic [15:0] count_nxt_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic        done_nxt_s;
    logic [15:0] digits_nxt_s;
    logic [15:0] count_dec_s;
    logic        preset_ok_s;
    logic [15:0] digits_r;
    logic        running_r;
    logic        done_r;
    logic        error_r;

    assign count_dec_s = bcd_dec(count_r);
    assign preset_ok_s = preset_valid(bus.preset_min, bus.preset_sec);

    // Next-state, count and prescaler decisions in fault > clear > load > pause > start order.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        presc_nxt_s = presc_r;
        done_nxt_s  = 1'b0;
        if (bus.fault) begin
            state_nxt_s = ST_ERROR;
        end else if (state_r == ST_ERROR) begin
            if (bus.clear) begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = 16'h0000;
                presc_nxt_s = '0;
            end else begin
                state_nxt_s = ST_ERROR;
            end
        end else if (bus.load) begin
            if (preset_ok_s) begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = {bus.preset_min, bus.preset_sec};
                presc_nxt_s = '0;
            end else begin
                state_nxt_s = ST_ERROR;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && (count_r == 16'h0000)) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else if (bus.start) begin
                        state_nxt_s = ST_RUNNING;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    if (bus.pause) begin
                        state_nxt_s = ST_PAUSED;
                    end else if (presc_r == PW'(TICK_DIV - 1)) begin
                        // Prescaler wrap is the one-second tick.
                        presc_nxt_s = '0;
                        count_nxt_s = count_dec_s;
                        if (count_dec_s == 16'h0000) begin
                            state_nxt_s = ST_DONE;
                            done_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_RUNNING;
                        end
                    end else begin
                        presc_nxt_s = presc_r + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (bus.start) begin
                        state_nxt_s = ST_RUNNING;
                    end else begin
                        state_nxt_s = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = 16'h0000;
                    presc_nxt_s = '0;
                end
            endcase
        end
    end

    assign digits_nxt_s = (state_nxt_s == ST_ERROR) ? ERRO_CODE : count_nxt_s;

    // State, count, prescaler and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            count_r   <= 16'h0000;
            presc_r   <= '0;
            digits_r  <= 16'h0000;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            presc_r   <= presc_nxt_s;
            digits_r  <= digits_nxt_s;
            running_r <= (state_nxt_s == ST_RUNNING);
            done_r    <= done_nxt_s;
            error_r   <= (state_nxt_s == ST_ERROR);
        end
    end

    assign bus.digits  = digits_r;
    assign bus.running = running_r;
    assign bus.done    = done_r;
    assign bus.error   = error_r;

`ifdef TIMER_DISPLAY_MUX_EN
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [3:0] scan_field(input logic [15:0] d, input logic [3:0] sel);
        case (sel)
            4'b0111: scan_field = d[15:12];
            4'b1011: scan_field = d[11:8];
            4'b1101: scan_field = d[7:4];
            4'b1110: scan_field = d[3:0];
            default: scan_field = 4'd0;
        endcase
    endfunction

    logic [SW-1:0] scan_cnt_r;
    logic [SW-1:0] scan_cnt_nxt_s;
    logic [3:0]    scan_sel_r;
    logic [3:0]    scan_sel_nxt_s;
    logic [3:0]    scan_data_r;

    // Scan slot counter; the active-low select rotates right on each wrap.
    always_comb begin
        if (scan_cnt_r == SW'(SCAN_DIV - 1)) begin
            scan_cnt_nxt_s = '0;
            scan_sel_nxt_s = {scan_sel_r[0], scan_sel_r[3:1]};
        end else begin
            scan_cnt_nxt_s = scan_cnt_r + SW'(1);
            scan_sel_nxt_s = scan_sel_r;
        end
    end

    // Scan registers; data follows the digit the next select will enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r  <= '0;
            scan_sel_r  <= 4'b0111;
            scan_data_r <= 4'd0;
        end else begin
            scan_cnt_r  <= scan_cnt_nxt_s;
            scan_sel_r  <= scan_sel_nxt_s;
            scan_data_r <= scan_field(digits_nxt_s, scan_sel_nxt_s);
        end
    end

    assign bus.scan_sel  = scan_sel_r;
    assign bus.scan_data = scan_data_r;
`endif

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown with TICK_DIV=4 (and SCAN_DIV=2 when the scan macro is defined).
module tb_timer_countdown;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    timer_countdown_if intf ();

    timer_countdown #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          reps;
        logic        ld;
        logic [7:0]  pm;
        logic [7:0]  ps;
        logic        st;
        logic        pa;
        logic        fa;
        logic        cl;
        logic [15:0] ed;
        logic        er;
        logic        edn;
        logic        eer;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input int reps, input logic ld, input logic [7:0] pm,
                       input logic [7:0] ps, input logic st, input logic pa, input logic fa,
                       input logic cl, input logic [15:0] ed, input logic er, input logic edn,
                       input logic eer);
        vec_t v;
        v.nm = nm; v.reps = reps; v.ld = ld; v.pm = pm; v.ps = ps; v.st = st; v.pa = pa;
        v.fa = fa; v.cl = cl; v.ed = ed; v.er = er; v.edn = edn; v.eer = eer;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] pm, input logic [7:0] ps,
                         input logic st, input logic pa, input logic fa, input logic cl);
        intf.load = ld; intf.preset_min = pm; intf.preset_sec = ps;
        intf.start = st; intf.pause = pa; intf.fault = fa; intf.clear = cl;
    endtask

    task automatic check_status(input string nm, input logic [15:0] ed, input logic er,
                                input logic edn, input logic eer);
        check({nm, ".digits"},  {16'h0000, intf.digits}, {16'h0000, ed});
        check({nm, ".running"}, {31'd0, intf.running},   {31'd0, er});
        check({nm, ".done"},    {31'd0, intf.done},      {31'd0, edn});
        check({nm, ".error"},   {31'd0, intf.error},     {31'd0, eer});
    endtask

    initial begin
        int cyc;
        logic seen;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_status("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef TIMER_DISPLAY_MUX_EN
        check("reset.scan_sel",  {28'd0, intf.scan_sel},  32'h7);
        check("reset.scan_data", {28'd0, intf.scan_data}, 32'h0);
`endif
        step();
        step();
        rst_n = 1'b1;

        //  name           reps ld pmin   psec   st pa fa cl  digits   run don err
        add("ld0003",      1, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        add("start3",      1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
        add("pre3",        3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
        add("tick2",       1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
        add("pre2",        3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
        add("tick1",       1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        add("pre1",        3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        add("tick0",       1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        add("donehold",    1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add("startdone",   1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add("ld1000",      1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        add("start1000",   1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0);
        add("pre1000",     3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0);
        add("borrow0959",  1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0959, 1'b1, 1'b0, 1'b0);
        add("pause0959",   1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0959, 1'b0, 1'b0, 1'b0);
        add("ld0005",      1, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
        add("start0005",   1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
        add("pre0005",     2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
        add("pausehold",  10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);
        add("resume",      1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
        add("resume1",     1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
        add("resumetick",  1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0);
        add("pausewins",   1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
        add("restart",     1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0);
        add("faultrun",    1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'hCEEF, 1'b0, 1'b0, 1'b1);
        add("ldinerr",     1, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCEEF, 1'b0, 1'b0, 1'b1);
        add("clear1",      1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        add("badsec60",    1, 1'b1, 8'h00, 8'h60, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCEEF, 1'b0, 1'b0, 1'b1);
        add("ldignored",   1, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCEEF, 1'b0, 1'b0, 1'b1);
        add("clear2",      1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        add("startzero",   1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        add("zeropulse",   1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add("badminA0",    1, 1'b1, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCEEF, 1'b0, 1'b0, 1'b1);
        add("faultclr",    1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hCEEF, 1'b0, 1'b0, 1'b1);
        add("clear3",      1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        add("ld9959",      1, 1'b1, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9959, 1'b0, 1'b0, 1'b0);
        add("badsec5A",    1, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCEEF, 1'b0, 1'b0, 1'b1);
        add("clear4",      1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].ld, vecs[i].pm, vecs[i].ps, vecs[i].st, vecs[i].pa,
                      vecs[i].fa, vecs[i].cl);
                step();
            end
            check_status(vecs[i].nm, vecs[i].ed, vecs[i].er, vecs[i].edn, vecs[i].eer);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Done pulse arrives 8 cycles after running rises for 00:02, lasting one cycle.
        drive(1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            seen = intf.done;
        end
        check("done.latency", cyc, 32'd8);
        check("done.running", {31'd0, intf.running}, 32'd0);
        step();
        check("done.width", {31'd0, intf.done}, 32'd0);

        // Asynchronous reset between edges while running.
        drive(1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("prerst.running", {31'd0, intf.running}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_status("asyncrst_run", 16'h0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();

        // Asynchronous reset between edges while in ERROR.
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("prerst.error", {31'd0, intf.error}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_status("asyncrst_err", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef TIMER_DISPLAY_MUX_EN
        check("asyncrst.scan_sel", {28'd0, intf.scan_sel}, 32'h7);
`endif
        #2;
        rst_n = 1'b1;
        step();

`ifdef TIMER_DISPLAY_MUX_EN
        begin
            logic [3:0] prev_sel;
            logic [3:0] exp_sel [4];
            exp_sel[0] = 4'b0111; exp_sel[1] = 4'b1011;
            exp_sel[2] = 4'b1101; exp_sel[3] = 4'b1110;
            drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            step();
            cyc  = 0;
            seen = 1'b0;
            prev_sel = intf.scan_sel;
            while (!seen && cyc < 12) begin
                step();
                cyc++;
                seen = (prev_sel == 4'b1110) && (intf.scan_sel == 4'b0111);
                prev_sel = intf.scan_sel;
            end
            check("scan.sync", {31'd0, seen}, 32'd1);
            for (int k = 0; k < 8; k++) begin
                if (k > 0) step();
                check("scan.sel",  {28'd0, intf.scan_sel},  {28'd0, exp_sel[k / 2]});
                check("scan.data", {28'd0, intf.scan_data}, k / 2 + 1);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
